// File: rtl/pn_pkg.sv
// Shared definitions for the pipelined permutation network: flit field defaults
// and the saturating age increment used by every compare-swap element.
package pn_pkg;

    localparam int PN_NUM_PORT   = 4;
    localparam int PN_WIDTH_FLIT = 64;
    localparam int PN_AGE_LSB    = 32;
    localparam int PN_AGE_W      = 8;
    // Valid and golden bits are placed relative to the top of the flit.
    localparam int PN_VALID_OFS  = 1;
    localparam int PN_GOLDEN_OFS = 2;

    function automatic logic [31:0] pn_age_inc_sat(input logic [31:0] age, input int age_w);
        logic [31:0] age_max;
        age_max = (age_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << age_w) - 32'd1);
        return (age >= age_max) ? age_max : age + 32'd1;
    endfunction

endpackage

// File: rtl/pipelined_permutation_network_cmp_swap.sv
// pn_cmp_swap: 2x2 compare-swap; the winner leaves on the lower lane, and both
// flits have their age bumped (saturating) when valid. Golden priority under PN_GOLDEN_EN.
module pn_cmp_swap
    import pn_pkg::*;
#(
    parameter int WIDTH_FLIT = PN_WIDTH_FLIT,
    parameter int AGE_LSB    = PN_AGE_LSB,
    parameter int AGE_W      = PN_AGE_W,
    parameter int VALID_BIT  = WIDTH_FLIT - PN_VALID_OFS
`ifdef PN_GOLDEN_EN
    ,
    parameter int GOLDEN_BIT = WIDTH_FLIT - PN_GOLDEN_OFS
`endif
) (
    input  logic [WIDTH_FLIT-1:0] lo_i,
    input  logic [WIDTH_FLIT-1:0] hi_i,
    output logic [WIDTH_FLIT-1:0] win_o,
    output logic [WIDTH_FLIT-1:0] lose_o
);

    function automatic logic [WIDTH_FLIT-1:0] age_bump(input logic [WIDTH_FLIT-1:0] f);
        logic [WIDTH_FLIT-1:0] r;
        r = f;
        if (f[VALID_BIT]) begin
            r[AGE_LSB +: AGE_W] = AGE_W'(pn_age_inc_sat(32'(f[AGE_LSB +: AGE_W]), AGE_W));
        end
        return r;
    endfunction

    logic             lo_v;
    logic             hi_v;
    logic [AGE_W-1:0] lo_age;
    logic [AGE_W-1:0] hi_age;
    logic             lo_wins;

    always_comb begin
        lo_v    = lo_i[VALID_BIT];
        hi_v    = hi_i[VALID_BIT];
        lo_age  = lo_i[AGE_LSB +: AGE_W];
        hi_age  = hi_i[AGE_LSB +: AGE_W];
        // Ties (and two invalid flits) keep the lower lane in front.
        lo_wins = 1'b1;
        if (lo_v != hi_v) begin
            lo_wins = lo_v;
`ifdef PN_GOLDEN_EN
        end else if (lo_v && (lo_i[GOLDEN_BIT] != hi_i[GOLDEN_BIT])) begin
            lo_wins = lo_i[GOLDEN_BIT];
`endif
        end else if (lo_v) begin
            lo_wins = (lo_age >= hi_age);
        end
        win_o  = age_bump(lo_wins ? lo_i : hi_i);
        lose_o = age_bump(lo_wins ? hi_i : lo_i);
    end

endmodule

// File: rtl/pipelined_permutation_network.sv
// Registered butterfly network that moves the highest-priority valid flit to lane 0
// in log2(NUM_PORT) stages. Optional golden-flit priority under PN_GOLDEN_EN.
module pipelined_permutation_network
    import pn_pkg::*;
#(
    parameter int NUM_PORT   = PN_NUM_PORT,
    parameter int WIDTH_FLIT = PN_WIDTH_FLIT,
    parameter int AGE_LSB    = PN_AGE_LSB,
    parameter int AGE_W      = PN_AGE_W,
    parameter int VALID_BIT  = WIDTH_FLIT - PN_VALID_OFS
`ifdef PN_GOLDEN_EN
    ,
    parameter int GOLDEN_BIT = WIDTH_FLIT - PN_GOLDEN_OFS
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           flush,
    input  logic [NUM_PORT*WIDTH_FLIT-1:0] din,
    output logic [NUM_PORT*WIDTH_FLIT-1:0] dout,
    output logic [NUM_PORT-1:0]            dout_valid
);

    localparam int S  = $clog2(NUM_PORT);
    localparam int NW = NUM_PORT * WIDTH_FLIT;

    logic [S-1:0][NW-1:0] stage_in;
    logic [S-1:0][NW-1:0] stage_d;
    logic [S-1:0][NW-1:0] stage_q;

    for (genvar s = 0; s < S; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign stage_in[s] = din;
        end else begin : g_next
            assign stage_in[s] = stage_q[s-1];
        end

        for (genvar p = 0; p < NUM_PORT/2; p++) begin : g_pair
            // Pair p of stage s: insert a zero at bit s of p to get the lower lane.
            localparam int LO = ((p >> s) << (s + 1)) | (p & ((1 << s) - 1));
            localparam int HI = LO + (1 << s);

            pn_cmp_swap #(
                .WIDTH_FLIT (WIDTH_FLIT),
                .AGE_LSB    (AGE_LSB),
                .AGE_W      (AGE_W),
                .VALID_BIT  (VALID_BIT)
`ifdef PN_GOLDEN_EN
                ,
                .GOLDEN_BIT (GOLDEN_BIT)
`endif
            ) u_cmp_swap (
                .lo_i   (stage_in[s][LO*WIDTH_FLIT +: WIDTH_FLIT]),
                .hi_i   (stage_in[s][HI*WIDTH_FLIT +: WIDTH_FLIT]),
                .win_o  (stage_d[s][LO*WIDTH_FLIT +: WIDTH_FLIT]),
                .lose_o (stage_d[s][HI*WIDTH_FLIT +: WIDTH_FLIT])
            );
        end
    end

    // en advances every stage at once; flush clears only the valid bits and
    // overrides en, so din presented on a flush edge is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (flush) begin
            for (int s = 0; s < S; s++) begin
                for (int l = 0; l < NUM_PORT; l++) begin
                    stage_q[s][l*WIDTH_FLIT + VALID_BIT] <= 1'b0;
                end
            end
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        dout = stage_q[S-1];
        for (int l = 0; l < NUM_PORT; l++) begin
            dout_valid[l] = stage_q[S-1][l*WIDTH_FLIT + VALID_BIT];
        end
    end

endmodule

// File: tb/tb_pipelined_permutation_network.sv
// Directed table-driven bench for pipelined_permutation_network (4 lanes, 64-bit flits),
// plus stall, flush and mid-flight reset sequences.
module tb_pipelined_permutation_network;

    localparam int NP = 4;
    localparam int W  = 64;
    localparam int NV = 9;

    logic              clk;
    logic              reset;
    logic              en;
    logic              flush;
    logic [NP*W-1:0]   din;
    logic [NP*W-1:0]   dout;
    logic [NP-1:0]     dout_valid;

    int checks = 0;
    int errors = 0;

    pipelined_permutation_network dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NP*W-1:0] din;
        logic [NP*W-1:0] exp;
        logic [NP-1:0]   exp_v;
    } vec_t;

    vec_t vt[NV];

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] DD = 32'hDDDD_0004;

    // valid | golden | 22-bit tag | age | 32-bit data
    function automatic logic [W-1:0] mk(input logic v, input logic g, input logic [7:0] age,
                                        input logic [31:0] data);
        return {v, g, data[21:0] ^ 22'h2A5A5, age, data};
    endfunction

    function automatic logic [NP*W-1:0] p4(input logic [W-1:0] f0, input logic [W-1:0] f1,
                                           input logic [W-1:0] f2, input logic [W-1:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic chk(input string name, input logic [NP*W-1:0] act, input logic [NP*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [NP*W-1:0] exp, input logic [NP-1:0] exp_v);
        for (int l = 0; l < NP; l++) begin
            chk($sformatf("%s_lane%0d", tag, l), dout[l*W +: W], exp[l*W +: W]);
        end
        chk($sformatf("%s_valid", tag), NP*W'(dout_valid), NP*W'(exp_v));
    endtask

    task automatic load(input logic [NP*W-1:0] v);
        din = v;
        en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{p4(mk(1,0,15,DA), mk(1,0,14,DB), mk(1,0,13,DC), mk(1,0,12,DD)),
                  p4(mk(1,0,17,DA), mk(1,0,16,DB), mk(1,0,15,DC), mk(1,0,14,DD)), 4'b1111};
        vt[1] = '{p4(mk(1,0,10,DA), mk(1,0,11,DB), mk(1,0,12,DC), mk(1,0,13,DD)),
                  p4(mk(1,0,15,DD), mk(1,0,14,DC), mk(1,0,13,DB), mk(1,0,12,DA)), 4'b1111};
        vt[2] = '{p4(mk(1,0,10,DA), mk(1,0,5,DB), mk(1,0,9,DC), mk(1,0,18,DD)),
                  p4(mk(1,0,20,DD), mk(1,0,11,DC), mk(1,0,12,DA), mk(1,0,7,DB)), 4'b1111};
        vt[3] = '{p4(mk(1,0,7,DA), mk(1,0,7,DB), mk(1,0,7,DC), mk(1,0,7,DD)),
                  p4(mk(1,0,9,DA), mk(1,0,9,DB), mk(1,0,9,DC), mk(1,0,9,DD)), 4'b1111};
        vt[4] = '{p4(mk(1,0,100,DA), mk(1,0,100,DB), mk(1,0,255,DC), mk(1,0,100,DD)),
                  p4(mk(1,0,255,DC), mk(1,0,102,DB), mk(1,0,102,DA), mk(1,0,102,DD)), 4'b1111};
        vt[5] = '{p4(mk(0,0,50,DA), mk(0,0,50,DB), mk(1,0,3,DC), mk(0,0,50,DD)),
                  p4(mk(1,0,5,DC), mk(0,0,50,DB), mk(0,0,50,DA), mk(0,0,50,DD)), 4'b0001};
`ifdef PN_GOLDEN_EN
        vt[6] = '{p4(mk(1,0,200,DA), mk(1,0,200,DB), mk(1,0,200,DC), mk(1,1,0,DD)),
                  p4(mk(1,1,2,DD), mk(1,0,202,DB), mk(1,0,202,DA), mk(1,0,202,DC)), 4'b1111};
`else
        vt[6] = '{p4(mk(1,0,200,DA), mk(1,0,200,DB), mk(1,0,200,DC), mk(1,1,0,DD)),
                  p4(mk(1,0,202,DA), mk(1,0,202,DB), mk(1,0,202,DC), mk(1,1,2,DD)), 4'b1111};
`endif
        vt[7] = '{p4(mk(0,0,1,DA), mk(0,1,2,DB), mk(0,0,3,DC), mk(0,0,4,DD)),
                  p4(mk(0,0,1,DA), mk(0,1,2,DB), mk(0,0,3,DC), mk(0,0,4,DD)), 4'b0000};
        vt[8] = '{p4(mk(1,0,1,DA), mk(0,0,9,DB), mk(0,0,9,DC), mk(1,0,1,DD)),
                  p4(mk(1,0,3,DA), mk(0,0,9,DB), mk(1,0,3,DD), mk(0,0,9,DC)), 4'b0101};

        // Asynchronous reset must clear the outputs with no clock edge.
        reset = 1'b1;
        en    = 1'b0;
        flush = 1'b0;
        din   = '0;
        #1;
        chk_out("reset", '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            load(vt[i].din);
            chk_out($sformatf("vec%0d", i), vt[i].exp, vt[i].exp_v);
        end

        // Stall: dout must hold and din must be ignored while en=0.
        load(vt[1].din);
        din = vt[0].din;
        @(negedge clk);
        en  = 1'b0;
        din = vt[2].din;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_out($sformatf("stall%0d", c), vt[1].exp, vt[1].exp_v);
        end
        en = 1'b1;
        @(negedge clk);
        chk_out("stall_resume", vt[0].exp, vt[0].exp_v);

        // Flush together with en: two empty outputs, then normal flow.
        load(vt[0].din);
        din   = vt[2].din;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out0_valid", NP*W'(dout_valid), '0);
        din = vt[3].din;
        @(negedge clk);
        chk("flush_out1_valid", NP*W'(dout_valid), '0);
        @(negedge clk);
        chk_out("flush_after", vt[3].exp, vt[3].exp_v);

        // Flush wins even with en low.
        en    = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_en0_valid", NP*W'(dout_valid), '0);

        // Reset mid-flight clears dout before the next rising edge.
        load(vt[0].din);
        #2;
        reset = 1'b1;
        #1;
        chk_out("reset_mid", '0, '0);
        @(negedge clk);
        reset = 1'b0;
        load(vt[4].din);
        chk_out("post_reset", vt[4].exp, vt[4].exp_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_permutation_network.md
PIPELINED_PERMUTATION_NETWORK -- requirements
Module: pipelined_permutation_network

Interface
REQ-001 SHALL have parameter NUM_PORT, default 4, number of lanes; power of two, 2..16.
REQ-002 SHALL have parameter WIDTH_FLIT, default 64, bits per flit.
REQ-003 SHALL have parameter AGE_LSB, default 32, LSB position of the age field in the flit.
REQ-004 SHALL have parameter AGE_W, default 8, age field width.
REQ-005 SHALL have parameter VALID_BIT, default WIDTH_FLIT-1, position of the flit valid bit.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, pipeline advance; 0 holds every stage.
REQ-009 SHALL have port flush, input, 1, synchronous clear of all stage valid bits.
REQ-010 SHALL have port din, input, NUM_PORT*WIDTH_FLIT, input flits; lane i at [i*WIDTH_FLIT +: WIDTH_FLIT].
REQ-011 SHALL have port dout, output, NUM_PORT*WIDTH_FLIT, output flits; lane 0 holds the highest priority.
REQ-012 SHALL have port dout_valid, output, NUM_PORT, a copy of each output lane's valid bit.

Function
REQ-013 SHALL contain S = log2(NUM_PORT) registered butterfly stages; stage s compares lanes i and i XOR 2^s.
REQ-014 SHALL order each compare pair lower-lane = winner, higher-lane = loser.
- REQ-014a: a valid flit beats an invalid flit.
- REQ-014b: otherwise the larger age (older flit) wins.
- REQ-014c: on equal age, the flit arriving on the lower lane wins.
REQ-015 SHALL have latency exactly S enabled cycles from din to dout; en=0 holds all stage registers, and din is not sampled.
REQ-016 SHALL increment the age of every valid flit by 1 at each stage capture, saturating at 2^AGE_W-1; invalid flits are passed unmodified.
REQ-017 SHALL leave all flit fields other than the age field bit-exact end to end.
REQ-018 SHALL guarantee that after the final stage, lane 0 holds a maximum-priority valid flit whenever any input was valid; full sorting of lanes 1..N-1 is not required.
REQ-019 SHALL conserve flits: the multiset of valid flits out equals the multiset in, with no drop and no duplication.
REQ-020 SHALL, on flush=1 at a rising edge, clear the valid bits of all stages regardless of en; flush has priority over en.
REQ-021 SHALL treat flush and en asserted together as a flush, with din discarded.

Reset
REQ-022 SHALL, while reset=1, immediately clear all stage registers to zero, so dout=0 and dout_valid=0.
REQ-023 SHALL, on reset asserted mid-operation, lose in-flight flits; the first capture after deassertion takes din normally.

Configuration
REQ-024 SHALL, when macro PN_GOLDEN_EN is defined, add parameter GOLDEN_BIT (default WIDTH_FLIT-2).
- REQ-024a: a valid flit with GOLDEN_BIT=1 beats any non-golden flit regardless of age.
- REQ-024b: between two golden flits, the REQ-014 rules apply.
REQ-025 SHALL, without PN_GOLDEN_EN, have no GOLDEN_BIT parameter, and that bit is treated as ordinary payload.

Structure
REQ-026 SHALL take the flit field position defaults (VALID_BIT, AGE_LSB, AGE_W, GOLDEN_BIT) and an age-saturate function from shared package pn_pkg.
REQ-027 SHALL instantiate the sub-module pn_cmp_swap (a 2x2 compare-swap with age increment) NUM_PORT/2 times per stage.

Verification
REQ-028 SHALL cover: ages 15,14,13,12, data A,B,C,D, all valid, en=1 -> after 2 cycles dout lanes A17,B16,C15,D14.
REQ-029 SHALL cover: ages 10,11,12,13 -> D15,C14,B13,A12; ages 10,5,9,18 -> D20,C11,A12,B7.
REQ-030 SHALL cover: all ages 7 -> output order A,B,C,D with all ages 9; age 255 on lane 2 -> lane 0 age 255, no wrap.
REQ-031 SHALL cover: only din2 valid -> dout0=C, dout_valid=0001; en=0 for 3 cycles mid-flight -> dout frozen, then completes, with latency counted in enabled cycles.
REQ-032 SHALL cover: flush during flight -> next two outputs dout_valid=0; reset pulse mid-flight -> dout=0 asynchronously before the next clk edge.
REQ-033 SHALL cover, with PN_GOLDEN_EN defined: golden flit on lane 3, age 0, others ages 200 -> dout0 is the golden flit, age 2.
